// File: rtl/ets_phase_stepper.sv
// DCM_SP variable phase-shift sequencer: walks PSEN/PSINCDEC one step at a time toward a
// signed target (loaded or auto-swept), tracks acknowledged phase, flags lock loss and timeouts.
//
// state     | meaning
// WAIT_LOCK | DCM not locked; applied phase is 0
// IDLE      | locked, evaluating current_phase against target
// ISSUE     | ps_en pulse cycle, direction latched
// WAIT_DONE | step outstanding, timeout running
// FAULT     | ps_done never arrived; held until rst
module ets_phase_stepper #(
    parameter int PHASE_WIDTH  = 9,
    parameter int MAX_PHASE    = 255,
    parameter int SWEEP_STEP   = 1,
    parameter int DONE_TIMEOUT = 64
) (
    input  logic                          ref_clk,
    input  logic                          rst,
    input  logic                          dcm_locked,
    input  logic signed [PHASE_WIDTH-1:0] target_phase,
    input  logic                          target_valid,
    input  logic                          sweep_enable,
    input  logic                          ps_done,
    output logic                          ps_en,
    output logic                          ps_incdec,
    output logic signed [PHASE_WIDTH-1:0] current_phase,
    output logic                          busy,
    output logic                          at_target,
    output logic                          sweep_wrap,
    output logic                          fault
);
    localparam int TW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
    localparam logic [TW-1:0]                 T_LOAD  = TW'(DONE_TIMEOUT - 1);
    localparam logic signed [PHASE_WIDTH-1:0] P_MAX   = PHASE_WIDTH'(MAX_PHASE);
    localparam logic signed [PHASE_WIDTH-1:0] P_MIN   = -P_MAX;
    localparam logic signed [PHASE_WIDTH-1:0] ONE     = PHASE_WIDTH'(1);
    localparam logic signed [PHASE_WIDTH:0]   P_MAX_X = (PHASE_WIDTH + 1)'(MAX_PHASE);
    localparam logic signed [PHASE_WIDTH:0]   STEP_X  = (PHASE_WIDTH + 1)'(SWEEP_STEP);

    typedef enum logic [2:0] {
        S_WAIT_LOCK,
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_FAULT
    } state_t;

    state_t                        state, state_n;
    logic signed [PHASE_WIDTH-1:0] target, target_n, phase_n, load_val;
    logic signed [PHASE_WIDTH:0]   sweep_sum;
    logic [TW-1:0]                 tmr, tmr_n;
    logic                          incdec_n, wrap_n, matched, arrived;

    always_comb begin
        state_n  = state;
        target_n = target;
        phase_n  = current_phase;
        incdec_n = ps_incdec;
        wrap_n   = 1'b0;
        tmr_n    = tmr;
        matched  = (current_phase == target);
        // one extra bit so the sweep overflow past +MAX_PHASE is visible
        sweep_sum = {target[PHASE_WIDTH-1], target} + STEP_X;

        load_val = target_phase;
        if (target_phase > P_MAX) begin
            load_val = P_MAX;
        end else if (target_phase < P_MIN) begin
            load_val = P_MIN;
        end

        case (state)
            S_WAIT_LOCK: begin
                if (dcm_locked) state_n = S_IDLE;
            end
            S_IDLE: begin
                if (!dcm_locked) begin
                    state_n = S_WAIT_LOCK;
                    phase_n = '0;
                end else if (!matched) begin
                    state_n  = S_ISSUE;
                    incdec_n = (target > current_phase);
                    tmr_n    = T_LOAD;
                end
            end
            S_ISSUE: begin
                tmr_n = tmr - TW'(1);
                if (!dcm_locked) begin
                    state_n = S_WAIT_LOCK;
                    phase_n = '0;
                end else begin
                    state_n = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!dcm_locked) begin
                    state_n = S_WAIT_LOCK;
                    phase_n = '0;
                end else if (ps_done) begin
                    state_n = S_IDLE;
                    phase_n = ps_incdec ? current_phase + ONE : current_phase - ONE;
                end else if (tmr == '0) begin
                    state_n = S_FAULT;
                end else begin
                    tmr_n = tmr - TW'(1);
                end
            end
            S_FAULT: begin
                state_n = S_FAULT;
            end
            default: begin
                state_n = S_WAIT_LOCK;
            end
        endcase

        // an explicit load outranks the sweep advance and suppresses its wrap pulse
        if (state != S_FAULT && target_valid) begin
            target_n = load_val;
        end else if (state == S_IDLE && dcm_locked && matched && sweep_enable) begin
            if (sweep_sum > P_MAX_X) begin
                target_n = P_MIN;
                wrap_n   = 1'b1;
            end else begin
                target_n = sweep_sum[PHASE_WIDTH-1:0];
            end
        end

        arrived = (state_n == S_IDLE) && (phase_n == target_n);
    end

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            state         <= S_WAIT_LOCK;
            target        <= '0;
            current_phase <= '0;
            tmr           <= '0;
            ps_en         <= 1'b0;
            ps_incdec     <= 1'b0;
            busy          <= 1'b1;
            at_target     <= 1'b0;
            sweep_wrap    <= 1'b0;
            fault         <= 1'b0;
        end else begin
            state         <= state_n;
            target        <= target_n;
            current_phase <= phase_n;
            tmr           <= tmr_n;
            ps_en         <= (state_n == S_ISSUE);
            ps_incdec     <= incdec_n;
            busy          <= !arrived;
            at_target     <= arrived;
            sweep_wrap    <= wrap_n;
            fault         <= (state_n == S_FAULT);
        end
    end
endmodule
